dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between the pipeline MEM stage (CPU requester) and the external debug/load port (EXT requester).
- Sits between the EX/MEM pipeline register outputs, the external port pins and the sram_BW64 data memory.
- Drives a stall back to the pipeline enable whenever the CPU loses arbitration.
- CPU has priority; a wait counter bounds EXT starvation; EXT can lock the port for multi-beat bursts.

Parameters:
- ADDR_W, 64, address width of both requesters and the memory.
- DATA_W, 64, data width.
- MAX_WAIT, 4, number of consecutive cycles EXT may be denied before it is forced to win (1..15).

Ports:
- clk  in  1  clock; everything samples on rising edge.
- arst_n  in  1  reset; synchronous, active-high (asserted = 1), sampled on rising clk.
- enable  in  1  CPU running; when 0 the CPU is treated as not requesting.
- cpu_ren  in  1  CPU read request (mem_read of EX/MEM).
- cpu_wen  in  1  CPU write request (mem_write of EX/MEM).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data to MEM/WB.
- cpu_stall  out  1  CPU request not served this cycle; pipeline must hold.
- ext_req  in  1  EXT request valid.
- ext_wen  in  1  EXT write (1) / read (0).
- ext_lock  in  1  keep ownership after this grant (burst).
- ext_addr  in  ADDR_W  EXT address.
- ext_wdata  in  DATA_W  EXT write data.
- ext_gnt  out  1  EXT request accepted this cycle.
- ext_rvalid  out  1  registered EXT read data valid.
- ext_rdata  out  DATA_W  registered EXT read data.
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  to memory.
- mem_ren, mem_wen  out  1  to memory.
- mem_rdata  in  DATA_W  memory read data, combinational (valid in the same cycle as mem_ren).

Behaviour:
- cpu_req = enable & (cpu_ren | cpu_wen). The arbitration decision and memory mux are combinational from the current state.
- States:
  - ARB: normal arbitration.
  - EXT_BURST: EXT owns the port.
- Reset (arst_n=1 at an edge) forces the following, aborting any burst or pending read without completing it:
  - state=ARB, wait_cnt=0.
  - ext_rvalid=0, ext_rdata=0.
- Outputs (combinational) during reset are the ARB-state decision with wait_cnt=0.
- ARB decision:
  - cpu_req & !(ext_req & wait_cnt==MAX_WAIT) -> grant CPU.
  - Else ext_req -> grant EXT.
  - Else idle: mem_ren=mem_wen=0, mem_addr/mem_wdata=0.
- EXT_BURST: EXT granted if ext_req; CPU never granted.
- CPU granted:
  - mem_* = cpu_*.
  - cpu_rdata = mem_rdata.
  - cpu_stall=0.
- EXT granted:
  - mem_addr=ext_addr, mem_wdata=ext_wdata, mem_wen=ext_wen, mem_ren=!ext_wen.
  - ext_gnt=1.
  - cpu_stall=cpu_req.
- cpu_rdata=0 when the CPU is not granted.
- cpu_stall=0 whenever cpu_req=0.
- wait_cnt (4 bits, saturating at MAX_WAIT):
  - Cleared on any EXT grant or when ext_req=0.
  - Otherwise incremented on every cycle with ext_req=1 and no EXT grant.
- Transitions:
  - ARB->EXT_BURST on EXT grant with ext_lock=1.
  - EXT_BURST->ARB on an EXT grant with ext_lock=0, or when ext_req=0.
  - Otherwise hold.
- ext_rvalid/ext_rdata:
  - ext_rvalid is registered one cycle after an EXT read grant (latency 1); ext_rdata captures mem_rdata on that grant.
  - ext_rvalid is 0 otherwise; ext_rdata holds its last value.
- Simultaneous CPU read+write asserted: treated as a write (mem_wen=1, mem_ren=0).
- enable=0: the CPU never wins and cpu_stall=0; EXT is granted every requesting cycle.
- EXT may drop ext_req mid-burst; the port returns to ARB next cycle with no lost CPU access (the CPU stalls until granted).

Test Plan:
- Reset, no requests -> after reset:
  - all mem_* = 0, cpu_stall=0, ext_gnt=0, ext_rvalid=0.
- CPU read only, addr 0x40, mem_rdata=0xDEAD -> same cycle: mem_ren=1, mem_addr=0x40, cpu_rdata=0xDEAD, cpu_stall=0.
- CPU and EXT (read, addr 0x80) both requesting continuously, MAX_WAIT=4:
  - CPU granted cycles 0-3 (wait_cnt 1..4).
  - Cycle 4: EXT granted, cpu_stall=1.
  - Cycle 5: ext_rvalid=1 with cycle-4 mem_rdata; CPU granted, wait_cnt=0.
- EXT write burst of 3 beats (ext_lock=1,1,0) while the CPU requests:
  - ext_gnt=1 for 3 cycles, cpu_stall=1 for 3 cycles.
  - 4th cycle: CPU granted, state=ARB.
- enable=0 with cpu_ren=1 and ext_req=1 -> EXT granted every cycle, cpu_stall=0, wait_cnt stays 0.
- Reset asserted mid-burst, with an EXT read granted the previous cycle:
  - Next cycle: state=ARB, ext_rvalid=0, ext_rdata=0.
  - A CPU request is granted immediately after reset releases.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between the CPU MEM stage and the external debug/load port
module dmem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {ARB, EXT_BURST} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t     state, next_state, cur_state;
    logic [3:0] wait_cnt, cur_wait, next_wait;
    logic       cpu_req, cpu_gnt;

    assign cpu_req = enable & (cpu_ren | cpu_wen);

    // While reset is held the decision is made as if already back in ARB with no wait history.
    assign cur_state = arst_n ? ARB : state;
    assign cur_wait  = arst_n ? 4'd0 : wait_cnt;

    always_comb begin
        cpu_gnt    = 1'b0;
        ext_gnt    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        cpu_rdata  = '0;
        next_state = cur_state;
        next_wait  = cur_wait;

        if (cur_state == ARB) begin
            if (cpu_req && !(ext_req && cur_wait == WAIT_MAX)) begin
                cpu_gnt = 1'b1;
            end else if (ext_req) begin
                ext_gnt = 1'b1;
            end
        end else begin
            ext_gnt = ext_req;
        end

        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wen   = cpu_wen;
            mem_ren   = cpu_ren & ~cpu_wen;
            cpu_rdata = mem_rdata;
        end else if (ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_wen   = ext_wen;
            mem_ren   = ~ext_wen;
        end

        if (ext_gnt || !ext_req) begin
            next_wait = 4'd0;
        end else if (cur_wait != WAIT_MAX) begin
            next_wait = cur_wait + 4'd1;
        end

        case (cur_state)
            ARB:       if (ext_gnt && ext_lock) next_state = EXT_BURST;
            EXT_BURST: if (!ext_req || (ext_gnt && !ext_lock)) next_state = ARB;
            default:   next_state = ARB;
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_ff @(posedge clk) begin
        if (arst_n) begin
            state      <= ARB;
            wait_cnt   <= 4'd0;
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            state      <= next_state;
            wait_cnt   <= next_wait;
            ext_rvalid <= ext_gnt & ~ext_wen;
            if (ext_gnt && !ext_wen) begin
                ext_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic        cpu_ren, cpu_wen;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_wen, ext_lock;
    logic [63:0] ext_addr, ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [63:0] ext_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(4)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_wen(ext_wen), .ext_lock(ext_lock),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b1; enable = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; ext_req = 1'b0; ext_wen = 1'b0;
        ext_lock = 1'b0; ext_addr = '0; ext_wdata = '0; mem_rdata = '0;
        tick(); tick();
        arst_n = 1'b0;
        #1;
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_ren", 64'(mem_ren), 0);
        check("rst_mem_wen", 64'(mem_wen), 0);
        check("rst_cpu_stall", 64'(cpu_stall), 0);
        check("rst_ext_gnt", 64'(ext_gnt), 0);
        check("rst_ext_rvalid", 64'(ext_rvalid), 0);

        // CPU read alone
        tick();
        enable = 1'b1; cpu_ren = 1'b1; cpu_addr = 64'h40; mem_rdata = 64'hDEAD;
        #1;
        check("cpu_rd_mem_ren", 64'(mem_ren), 1);
        check("cpu_rd_mem_addr", mem_addr, 64'h40);
        check("cpu_rd_rdata", cpu_rdata, 64'hDEAD);
        check("cpu_rd_stall", 64'(cpu_stall), 0);

        // CPU read+write together behaves as a write
        tick();
        cpu_wen = 1'b1; cpu_wdata = 64'h1234;
        #1;
        check("cpu_rw_mem_wen", 64'(mem_wen), 1);
        check("cpu_rw_mem_ren", 64'(mem_ren), 0);
        check("cpu_rw_mem_wdata", mem_wdata, 64'h1234);
        tick();
        cpu_wen = 1'b0;

        // CPU vs EXT read contention: EXT forced through after MAX_WAIT denials
        ext_req = 1'b1; ext_wen = 1'b0; ext_addr = 64'h80;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 64'h100 + 64'(i);
            #1;
            check($sformatf("cont_c%0d_gnt", i), 64'(ext_gnt), 0);
            check($sformatf("cont_c%0d_addr", i), mem_addr, 64'h40);
            check($sformatf("cont_c%0d_stall", i), 64'(cpu_stall), 0);
            tick();
        end
        mem_rdata = 64'hBEEF;
        #1;
        check("cont_c4_gnt", 64'(ext_gnt), 1);
        check("cont_c4_stall", 64'(cpu_stall), 1);
        check("cont_c4_addr", mem_addr, 64'h80);
        check("cont_c4_ren", 64'(mem_ren), 1);
        check("cont_c4_cpu_rdata", cpu_rdata, 0);
        tick();
        mem_rdata = 64'h5A5A;
        #1;
        check("cont_c5_rvalid", 64'(ext_rvalid), 1);
        check("cont_c5_rdata", ext_rdata, 64'hBEEF);
        check("cont_c5_gnt", 64'(ext_gnt), 0);
        check("cont_c5_cpu_rdata", cpu_rdata, 64'h5A5A);
        tick();
        #1;
        check("cont_c6_rvalid", 64'(ext_rvalid), 0);
        check("cont_c6_rdata_hold", ext_rdata, 64'hBEEF);
        ext_req = 1'b0;
        tick();

        // EXT write burst of three beats while the CPU keeps requesting
        ext_req = 1'b1; ext_wen = 1'b1; ext_lock = 1'b1;
        ext_addr = 64'h200; ext_wdata = 64'hAA;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("burst_pre%0d_gnt", i), 64'(ext_gnt), 0);
            tick();
        end
        #1;
        check("burst_b0_gnt", 64'(ext_gnt), 1);
        check("burst_b0_stall", 64'(cpu_stall), 1);
        check("burst_b0_wen", 64'(mem_wen), 1);
        check("burst_b0_ren", 64'(mem_ren), 0);
        check("burst_b0_wdata", mem_wdata, 64'hAA);
        tick();
        ext_addr = 64'h208;
        #1;
        check("burst_b1_gnt", 64'(ext_gnt), 1);
        check("burst_b1_stall", 64'(cpu_stall), 1);
        check("burst_b1_addr", mem_addr, 64'h208);
        tick();
        ext_addr = 64'h210; ext_lock = 1'b0;
        #1;
        check("burst_b2_gnt", 64'(ext_gnt), 1);
        check("burst_b2_stall", 64'(cpu_stall), 1);
        tick();
        #1;
        check("burst_end_gnt", 64'(ext_gnt), 0);
        check("burst_end_stall", 64'(cpu_stall), 0);
        check("burst_end_addr", mem_addr, 64'h40);
        check("burst_end_rvalid", 64'(ext_rvalid), 0);
        tick();

        // CPU disabled: EXT granted every cycle, no stall
        enable = 1'b0; ext_wen = 1'b0; ext_addr = 64'h300;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("dis%0d_gnt", i), 64'(ext_gnt), 1);
            check($sformatf("dis%0d_stall", i), 64'(cpu_stall), 0);
            check($sformatf("dis%0d_addr", i), mem_addr, 64'h300);
            tick();
        end
        enable = 1'b1;
        #1;
        check("reen_cpu_wins", 64'(ext_gnt), 0);
        tick();

        // Reset asserted mid-burst right after an EXT read grant
        enable = 1'b0; ext_lock = 1'b1; mem_rdata = 64'h5555;
        #1;
        check("rb_a0_gnt", 64'(ext_gnt), 1);
        tick();
        mem_rdata = 64'h7777;
        #1;
        check("rb_a1_gnt", 64'(ext_gnt), 1);
        tick();
        arst_n = 1'b1; enable = 1'b1;
        #1;
        check("rb_rst_rvalid", 64'(ext_rvalid), 1);
        check("rb_rst_rdata", ext_rdata, 64'h7777);
        check("rb_rst_arb_gnt", 64'(ext_gnt), 0);
        check("rb_rst_stall", 64'(cpu_stall), 0);
        tick();
        arst_n = 1'b0;
        #1;
        check("rb_post_rvalid", 64'(ext_rvalid), 0);
        check("rb_post_rdata", ext_rdata, 0);
        check("rb_post_gnt", 64'(ext_gnt), 0);
        check("rb_post_stall", 64'(cpu_stall), 0);
        check("rb_post_addr", mem_addr, 64'h40);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
